// File: rtl/alu_operand_stage.sv
// Register file and operand pipeline register feeding the ALU. Same-cycle
// writebacks are forwarded to the read ports and into held operands during stalls.
module alu_operand_stage #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CTRL_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic                     ALUsrc,
  input  logic [CTRL_WIDTH-1:0]    ALUctrl_in,
  input  logic                     RegWrite_in,
  input  logic                     WE3,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUop1,
  output logic [DATA_WIDTH-1:0]    ALUop2,
  output logic [CTRL_WIDTH-1:0]    ALUctrl,
  output logic [ADDRESS_WIDTH-1:0] rd_out,
  output logic                     RegWrite_out,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREGS  = 2 ** ADDRESS_WIDTH;
  localparam int A0_IDX = 10;
  localparam logic [DATA_WIDTH-1:0]    DZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] AZERO = {ADDRESS_WIDTH{1'b0}};
  localparam logic [CTRL_WIDTH-1:0]    CZERO = {CTRL_WIDTH{1'b0}};

  // Index 0 always reads as zero; otherwise a same-cycle writeback wins over the array.
  function automatic logic [DATA_WIDTH-1:0] bypass_read(
    input logic [ADDRESS_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]    arr_val,
    input logic                     we,
    input logic [ADDRESS_WIDTH-1:0] ad,
    input logic [DATA_WIDTH-1:0]    wd
  );
    logic [DATA_WIDTH-1:0] res;
    if (idx == AZERO) begin
      res = DZERO;
    end else if (we && (ad == idx)) begin
      res = wd;
    end else begin
      res = arr_val;
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0]    rf_q [NREGS];
  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    op1_q, op1_d;
  logic [DATA_WIDTH-1:0]    op2_q, op2_d;
  logic [CTRL_WIDTH-1:0]    ctrl_q, ctrl_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic                     rw_q, rw_d;
  logic [ADDRESS_WIDTH-1:0] hrs1_q, hrs1_d;
  logic [ADDRESS_WIDTH-1:0] hrs2_q, hrs2_d;
  logic                     hsrc_q, hsrc_d;
  logic                     accept_s;
  logic                     wb_live_s;
  logic [DATA_WIDTH-1:0]    rdata1_s, rdata2_s;

  assign in_ready  = !valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign wb_live_s = WE3 && (AD3 != AZERO);
  assign rdata1_s  = bypass_read(rs1, rf_q[rs1], WE3, AD3, WD3);
  assign rdata2_s  = bypass_read(rs2, rf_q[rs2], WE3, AD3, WD3);

  // Register file writeback, independent of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= DZERO;
      end
    end else if (wb_live_s) begin
      rf_q[AD3] <= WD3;
    end else begin
      rf_q[AZERO] <= DZERO;
    end
  end

  // Pipeline next state: reload on accept, otherwise drain and refresh held operands.
  always_comb begin
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    hrs1_d  = hrs1_q;
    hrs2_d  = hrs2_q;
    hsrc_d  = hsrc_q;
    if (accept_s) begin
      valid_d = 1'b1;
      op1_d   = rdata1_s;
      op2_d   = ALUsrc ? ImmOp : rdata2_s;
      ctrl_d  = ALUctrl_in;
      rd_d    = rd;
      rw_d    = RegWrite_in;
      hrs1_d  = rs1;
      hrs2_d  = rs2;
      hsrc_d  = ALUsrc;
    end else begin
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      if (valid_q && wb_live_s && (AD3 == hrs1_q)) begin
        op1_d = WD3;
      end else begin
        op1_d = op1_q;
      end
      if (valid_q && wb_live_s && !hsrc_q && (AD3 == hrs2_q)) begin
        op2_d = WD3;
      end else begin
        op2_d = op2_q;
      end
    end
  end

  // Operand pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op1_q   <= DZERO;
      op2_q   <= DZERO;
      ctrl_q  <= CZERO;
      rd_q    <= AZERO;
      rw_q    <= 1'b0;
      hrs1_q  <= AZERO;
      hrs2_q  <= AZERO;
      hsrc_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      hrs1_q  <= hrs1_d;
      hrs2_q  <= hrs2_d;
      hsrc_q  <= hsrc_d;
    end
  end

  assign out_valid    = valid_q;
  assign ALUop1       = op1_q;
  assign ALUop2       = op2_q;
  assign ALUctrl      = ctrl_q;
  assign rd_out       = rd_q;
  assign RegWrite_out = rw_q;

  generate
    if (NREGS > A0_IDX) begin : g_a0
      assign a0 = rf_q[A0_IDX];
    end else begin : g_no_a0
      assign a0 = DZERO;
    end
  endgenerate

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Register file plus operand pipeline register, directly upstream of the ALU.
- Accepts decoded instruction fields over a valid/ready handshake and reads rs1/rs2 from a 2^ADDRESS_WIDTH x DATA_WIDTH register file.
- Selects the second operand as either the register value or the immediate, and holds ALUop1/ALUop2/ALUctrl in a pipeline register that the ALU consumes.
- Takes the writeback port from the downstream stage and bypasses same-cycle writes to the read ports.

Parameters:
- ADDRESS_WIDTH, 5, register index width; the register file has 2^ADDRESS_WIDTH entries.
- DATA_WIDTH, 32, register, immediate and operand width.
- CTRL_WIDTH, 3, ALU control width; matches the ALU's ALUctrl.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction fields are valid.
- in_ready  out  1  stage can accept this cycle.
- rs1  in  ADDRESS_WIDTH  source register 1 index.
- rs2  in  ADDRESS_WIDTH  source register 2 index.
- rd  in  ADDRESS_WIDTH  destination index, passed through.
- ImmOp  in  DATA_WIDTH  sign-extended immediate.
- ALUsrc  in  1  1: op2 = ImmOp; 0: op2 = reg[rs2].
- ALUctrl_in  in  CTRL_WIDTH  ALU operation, passed through.
- RegWrite_in  in  1  destination write enable, passed through.
- WE3  in  1  writeback enable.
- AD3  in  ADDRESS_WIDTH  writeback index.
- WD3  in  DATA_WIDTH  writeback data.
- out_valid  out  1  held operands valid to the ALU.
- out_ready  in  1  ALU side consumes this cycle.
- ALUop1  out  DATA_WIDTH  operand 1.
- ALUop2  out  DATA_WIDTH  operand 2.
- ALUctrl  out  CTRL_WIDTH  registered ALU control.
- rd_out  out  ADDRESS_WIDTH  registered rd.
- RegWrite_out  out  1  registered RegWrite.
- a0  out  DATA_WIDTH  continuous view of register 10, for debug and test.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers clear to 0.
  - out_valid=0; ALUop1, ALUop2, ALUctrl, rd_out, RegWrite_out, a0 = 0.
  - in_ready is 1 from the first cycle after release.
  - Reset mid-operation discards any held instruction and all register contents.
- Register 0 is hardwired to zero: writes with AD3=0 are ignored, and reads of index 0 return 0, including under bypass.
- Writeback: on a rising edge with WE3=1 and AD3!=0, reg[AD3] <= WD3. Writeback is independent of the handshake and occurs whether or not the stage is stalled.
- Bypass: a read of index r in the same cycle as WE3=1, AD3=r, r!=0 returns WD3, not the stale array value.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - On accept, the pipeline register loads:
    - ALUop1 = bypassed reg[rs1];
    - ALUop2 = ALUsrc ? ImmOp : bypassed reg[rs2];
    - ALUctrl, rd_out and RegWrite_out from the inputs;
    - out_valid <= 1.
  - Latency: operands appear on the outputs 1 cycle after accept.
  - If out_valid && out_ready && !accept, then out_valid <= 0.
  - Simultaneous consume and accept: the register reloads and out_valid stays 1. Full throughput is 1 instruction per cycle.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable. Exception: held-operand refresh.
- Held-operand refresh:
  - The stage stores the held rs1 index, rs2 index and ALUsrc.
  - While out_valid=1 and the stage is not reloading this cycle, a writeback with WE3=1, AD3!=0 and AD3 equal to the held rs1 updates ALUop1 <= WD3.
  - The same rule applies to ALUop2 when held ALUsrc=0 and AD3 equals the held rs2.
  - The refreshed value is visible the next cycle.
  - When the held rs1 equals the held rs2, both operands update.
- ALUctrl codes are passed through unchecked; validity checking is the ALU's job.
- No arithmetic is performed in this stage; all widths pass through unchanged.

Test Plan:
1. Reset, then write 5 to x10 (WE3=1, AD3=10, WD3=5) -> next cycle a0=5. Write to x0 with WD3=7 -> a read of rs1=0 gives ALUop1=0.
2. x1=3, x2=9. Accept rs1=1, rs2=2, ALUsrc=0, ALUctrl_in=001, out_ready=1 -> next cycle out_valid=1, ALUop1=3, ALUop2=9, ALUctrl=001. Then with in_valid=0, out_valid drops after one cycle.
3. Bypass: in the accept cycle of rs1=4, drive WE3=1, AD3=4, WD3=0x1234 -> ALUop1=0x1234. The same test with ALUsrc=1 and ImmOp=0xFFFFFFFF -> ALUop2=0xFFFFFFFF.
4. Stall: out_ready=0 with the stage full -> in_ready=0 and outputs hold for 3 cycles. A writeback to the held rs2 (ALUsrc=0) with WD3=42 -> ALUop2=42 next cycle. Raising out_ready completes consume; a new accept occurs in the same cycle.
5. Back-to-back: 4 instructions with in_valid=1 and out_ready=1 continuously -> 4 consecutive out_valid cycles with the correct operands in order and no bubbles.
6. Stage full with operands held. Assert rst_n=0 asynchronously mid-cycle -> out_valid=0 and ALUop1=0 immediately. After release, a read of x1 returns 0.
